// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with FWFT or registered-read output, occupancy count, flush,
// and sticky overflow/underflow flags. Push/pop use a valid/ready handshake.
module sync_fifo_flex #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter bit FWFT       = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_valid_s,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_ready_s,
    input  logic                  i_ready_m,
    output logic                  o_valid_m,
    output logic [DATA_WIDTH-1:0] o_dataout,
    input  logic [ADDR_WIDTH-1:0] i_almostfull_lvl,
    input  logic [ADDR_WIDTH-1:0] i_almostempty_lvl,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almostfull,
    output logic                  o_almostempty,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   free_cnt;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Pointer MSBs differ only when the write side has lapped the read side.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
        push  = i_valid_s && !full;
        pop   = i_ready_m && !empty;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ONE_C;
            if (pop)
                rd_ptr <= rd_ptr + ONE_C;
            if (push && !pop)
                count <= count + ONE_C;
            else if (pop && !push)
                count <= count - ONE_C;
            if (i_valid_s && full)
                overflow <= 1'b1;
            if (i_ready_m && empty)
                underflow <= 1'b1;
        end
    end

    // Storage is never cleared; flush and reset only move the pointers.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst && !i_flush)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_datain;
    end

    generate
        if (FWFT) begin : g_fwft
            assign o_dataout = mem[rd_ptr[ADDR_WIDTH-1:0]];
        end else begin : g_regread
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge i_clk) begin
                if (i_rst)
                    dout_q <= '0;
                else if (pop && !i_flush)
                    dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            assign o_dataout = dout_q;
        end
    endgenerate

    always_comb begin
        free_cnt      = DEPTH_C - count;
        o_count       = count;
        o_full        = full;
        o_empty       = empty;
        o_ready_s     = !full;
        o_valid_m     = !empty;
        o_almostfull  = (free_cnt <= {1'b0, i_almostfull_lvl});
        o_almostempty = (count <= {1'b0, i_almostempty_lvl});
        o_overflow    = overflow;
        o_underflow   = underflow;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed and scoreboard bench for sync_fifo_flex; one FWFT and one registered-read
// instance share the same stimulus so both read modes are checked each cycle.
module tb_sync_fifo_flex;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst, flush, valid_s, ready_m;
    logic [DW-1:0] datain;
    logic [AW-1:0] af_lvl, ae_lvl;

    logic          f_ready, f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [DW-1:0] f_dout;
    logic [AW:0]   f_count;
    logic          r_ready, r_valid, r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
    logic [DW-1:0] r_dout;
    logic [AW:0]   r_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid_s(valid_s), .i_datain(datain),
        .o_ready_s(f_ready), .i_ready_m(ready_m), .o_valid_m(f_valid), .o_dataout(f_dout),
        .i_almostfull_lvl(af_lvl), .i_almostempty_lvl(ae_lvl), .o_count(f_count),
        .o_full(f_full), .o_empty(f_empty), .o_almostfull(f_afull), .o_almostempty(f_aempty),
        .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    sync_fifo_flex #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) u_reg (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid_s(valid_s), .i_datain(datain),
        .o_ready_s(r_ready), .i_ready_m(ready_m), .o_valid_m(r_valid), .o_dataout(r_dout),
        .i_almostfull_lvl(af_lvl), .i_almostempty_lvl(ae_lvl), .o_count(r_count),
        .o_full(r_full), .o_empty(r_empty), .o_almostfull(r_afull), .o_almostempty(r_aempty),
        .o_overflow(r_ovf), .o_underflow(r_unf)
    );

    typedef struct {
        logic          v, r, fl, rs;
        logic [DW-1:0] din;
        logic [AW-1:0] laf, lae;
        logic [AW:0]   cnt;
        logic          full, empty, afull, aempty, ovf, unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, r, fl, rs, input logic [DW-1:0] din,
                                input logic [AW-1:0] laf, lae, input logic [AW:0] cnt,
                                input logic full, empty, afull, aempty, ovf, unf);
        vec_t t;
        t.v = v; t.r = r; t.fl = fl; t.rs = rs; t.din = din; t.laf = laf; t.lae = lae;
        t.cnt = cnt; t.full = full; t.empty = empty; t.afull = afull; t.aempty = aempty;
        t.ovf = ovf; t.unf = unf;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, r, fl, rs, input logic [DW-1:0] din);
        valid_s = v; ready_m = r; flush = fl; rst = rs; datain = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_count"},  32'(f_count), 32'd0);
        chk({tag, "_empty"},  32'(f_empty), 32'd1);
        chk({tag, "_valid"},  32'(f_valid), 32'd0);
        chk({tag, "_full"},   32'(f_full), 32'd0);
        chk({tag, "_ready"},  32'(f_ready), 32'd1);
        chk({tag, "_aempty"}, 32'(f_aempty), 32'd1);
        chk({tag, "_afull"},  32'(f_afull), 32'd0);
        chk({tag, "_ovf"},    32'(f_ovf), 32'd0);
        chk({tag, "_unf"},    32'(f_unf), 32'd0);
        chk({tag, "_rdout"},  r_dout, 32'd0);
        chk({tag, "_rcount"}, 32'(r_count), 32'd0);
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_word;

    initial begin
        logic [DW-1:0] m_reg;
        logic          m_ovf, m_unf;
        int            n, pv, pr;
        logic          v, r, fl, rs;
        logic [DW-1:0] d;

        af_lvl = 4'd2; ae_lvl = 4'd2;
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check_reset("reset");

        // Fill 16 words, then overflow, full push+pop, flush, underflow, reset.
        for (int k = 1; k <= DEPTH; k++)
            vecs.push_back(mk(1, 0, 0, 0, DW'(k - 1), 2, 2, (AW+1)'(k), k == DEPTH, 0,
                              (DEPTH - k) <= 2, k <= 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'hEE, 2, 2, 16, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h00, 2, 2, 16, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'hEF, 2, 2, 15, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h11, 2, 2, 0,  0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 2, 2, 0,  0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 32'h00, 2, 2, 0,  0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h77, 2, 2, 1,  0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h00, 2, 2, 0,  0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 1, 32'h33, 2, 2, 0,  0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h44, 2, 2, 1,  0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h00, 15, 0, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h00, 0, 1, 1,  0, 0, 0, 1, 0, 0));

        foreach (vecs[i]) begin
            af_lvl = vecs[i].laf; ae_lvl = vecs[i].lae;
            drive(vecs[i].v, vecs[i].r, vecs[i].fl, vecs[i].rs, vecs[i].din);
            chk($sformatf("vec%0d_count", i),  32'(f_count),  32'(vecs[i].cnt));
            chk($sformatf("vec%0d_full", i),   32'(f_full),   32'(vecs[i].full));
            chk($sformatf("vec%0d_ready", i),  32'(f_ready),  32'(!vecs[i].full));
            chk($sformatf("vec%0d_empty", i),  32'(f_empty),  32'(vecs[i].empty));
            chk($sformatf("vec%0d_valid", i),  32'(f_valid),  32'(!vecs[i].empty));
            chk($sformatf("vec%0d_afull", i),  32'(f_afull),  32'(vecs[i].afull));
            chk($sformatf("vec%0d_aempty", i), 32'(f_aempty), 32'(vecs[i].aempty));
            chk($sformatf("vec%0d_ovf", i),    32'(f_ovf),    32'(vecs[i].ovf));
            chk($sformatf("vec%0d_unf", i),    32'(f_unf),    32'(vecs[i].unf));
            chk($sformatf("vec%0d_rcount", i), 32'(r_count),  32'(vecs[i].cnt));
        end
        af_lvl = 4'd2; ae_lvl = 4'd2;

        // Read latency: FWFT shows the word without a pop; registered mode after the pop.
        drive(0, 0, 1, 0, '0);
        drive(1, 0, 0, 0, 32'hA5);
        chk("fwft_a5_nopop", f_dout, 32'hA5);
        chk("reg_before_pop", r_dout, 32'h0);
        drive(0, 1, 0, 0, '0);
        chk("reg_after_pop", r_dout, 32'hA5);
        drive(0, 0, 0, 0, '0);
        chk("reg_hold", r_dout, 32'hA5);

        // Steady half-full streaming across several pointer wraps.
        drive(0, 0, 1, 0, '0);
        q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 32'h100 + DW'(i));
            q.push_back(32'h100 + DW'(i));
        end
        for (int j = 0; j < 40; j++) begin
            exp_word = q.pop_front();
            q.push_back(32'h200 + DW'(j));
            drive(1, 1, 0, 0, 32'h200 + DW'(j));
            chk($sformatf("stream%0d_count", j), 32'(f_count), 32'd8);
            chk($sformatf("stream%0d_rdout", j), r_dout, exp_word);
            chk($sformatf("stream%0d_fdout", j), f_dout, q[0]);
        end

        // Simultaneous push+pop on empty keeps the word; reset then discards everything.
        drive(0, 0, 1, 0, '0);
        drive(1, 1, 0, 0, 32'h5A);
        chk("pp_empty_count", 32'(f_count), 32'd1);
        chk("pp_empty_unf", 32'(f_unf), 32'd1);
        chk("pp_empty_data", f_dout, 32'h5A);
        drive(1, 0, 0, 0, 32'h6B);
        drive(1, 1, 0, 1, 32'h7C);
        check_reset("midrst");

        // Random traffic against a queue model.
        q.delete();
        m_reg = '0; m_ovf = 1'b0; m_unf = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            pv = ((c / 400) % 2 == 0) ? 70 : 30;
            pr = 100 - pv;
            v  = ($urandom_range(0, 99) < pv);
            r  = ($urandom_range(0, 99) < pr);
            fl = ($urandom_range(0, 299) == 0);
            rs = ($urandom_range(0, 999) == 0);
            d  = $urandom;
            case ($urandom_range(0, 2))
                0: af_lvl = 4'd0;
                1: af_lvl = 4'd1;
                default: af_lvl = 4'd15;
            endcase
            case ($urandom_range(0, 2))
                0: ae_lvl = 4'd0;
                1: ae_lvl = 4'd1;
                default: ae_lvl = 4'd15;
            endcase
            if (rs || fl) begin
                q.delete();
                m_ovf = 1'b0; m_unf = 1'b0;
                if (rs) m_reg = '0;
            end else begin
                n = q.size();
                if (v && n == DEPTH) m_ovf = 1'b1;
                if (r && n == 0) m_unf = 1'b1;
                if (r && n > 0) m_reg = q.pop_front();
                if (v && n < DEPTH) q.push_back(d);
            end
            drive(v, r, fl, rs, d);
            n = q.size();
            chk("rnd_count", 32'(f_count), 32'(n));
            chk("rnd_full", 32'(f_full), 32'(n == DEPTH));
            chk("rnd_empty", 32'(f_empty), 32'(n == 0));
            chk("rnd_afull", 32'(f_afull), 32'((DEPTH - n) <= int'(af_lvl)));
            chk("rnd_aempty", 32'(f_aempty), 32'(n <= int'(ae_lvl)));
            chk("rnd_ovf", 32'(f_ovf), 32'(m_ovf));
            chk("rnd_unf", 32'(f_unf), 32'(m_unf));
            chk("rnd_rdout", r_dout, m_reg);
            chk("rnd_rcount", 32'(r_count), 32'(n));
            if (n > 0)
                chk("rnd_fdout", f_dout, q[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
